// File: rtl/acc_pkg.sv
// Shared types and the width-generic saturating add used by the accumulator channels.
// Arithmetic is done in a fixed ACC_CALC_W signed domain so one function covers every WIDTH.
package acc_pkg;

    localparam int unsigned ACC_MAX_W  = 32;
    localparam int unsigned ACC_CALC_W = ACC_MAX_W + 2;

    typedef enum logic {
        ACC_UNSIGNED = 1'b0,
        ACC_SIGNED   = 1'b1
    } acc_mode_e;

    typedef logic signed [ACC_CALC_W-1:0] calc_t;

    typedef struct packed {
        logic                 sat;
        logic [ACC_MAX_W-1:0] value;
    } sat_res_t;

    // Upper clamp limit for a w-bit operand in the given mode.
    function automatic calc_t sat_hi(acc_mode_e mode, int unsigned w);
        if (mode == ACC_SIGNED) begin
            return (calc_t'(1) << (w - 1)) - calc_t'(1);
        end
        return (calc_t'(1) << w) - calc_t'(1);
    endfunction

    // Lower clamp limit; ~hi is -2^(w-1) for the signed case.
    function automatic calc_t sat_lo(acc_mode_e mode, int unsigned w);
        if (mode == ACC_SIGNED) begin
            return ~sat_hi(mode, w);
        end
        return '0;
    endfunction

    // Sign- or zero-extend the low w bits of x into the calculation domain.
    function automatic calc_t extend(acc_mode_e mode, logic [ACC_MAX_W-1:0] x, int unsigned w);
        calc_t t;
        t = calc_t'(x) << (ACC_CALC_W - w);
        if (mode == ACC_SIGNED) begin
            return t >>> (ACC_CALC_W - w);
        end
        return t >> (ACC_CALC_W - w);
    endfunction

    function automatic sat_res_t sat_add(acc_mode_e mode, logic [ACC_MAX_W-1:0] a,
                                         logic [ACC_MAX_W-1:0] b, int unsigned w);
        calc_t    s;
        calc_t    hi;
        calc_t    lo;
        sat_res_t r;
        s  = extend(mode, a, w) + extend(mode, b, w);
        hi = sat_hi(mode, w);
        lo = sat_lo(mode, w);
        r.sat   = 1'b0;
        r.value = s[ACC_MAX_W-1:0];
        if (s > hi) begin
            r.sat   = 1'b1;
            r.value = hi[ACC_MAX_W-1:0];
        end else if (s < lo) begin
            r.sat   = 1'b1;
            r.value = lo[ACC_MAX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_sat_add.sv
// Combinational WIDTH-bit saturating adder; mode selects signed or unsigned clamping.
module acc_sat_add
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  acc_mode_e        mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum_c,
    output logic             sat_c
);

    sat_res_t res;

    always_comb begin
        res = sat_add(mode, ACC_MAX_W'(a), ACC_MAX_W'(b), WIDTH);
    end

    assign sum_c = res.value[WIDTH-1:0];
    assign sat_c = res.sat;

    // Clamped result always fits in WIDTH bits; the upper calculation bits are don't-care.
    generate
        if (WIDTH < ACC_MAX_W) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^res.value[ACC_MAX_W-1:WIDTH];
        end
    endgenerate

endmodule

// File: rtl/acc_sat_chan.sv
// Multi-channel saturating accumulator with a single registered valid/ready result stage.
// Each channel is independently signed or unsigned; results are extended to WIDTH+1 bits.
module acc_sat_chan
    import acc_pkg::*;
#(
    parameter int unsigned         WIDTH       = 4,
    parameter int unsigned         NCH         = 2,
    parameter logic [NCH-1:0]      SIGNED_MASK = {NCH{1'b1}},
    localparam int unsigned        CHW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CHW-1:0]          in_ch,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CHW-1:0]          out_ch,
    output logic signed [WIDTH:0]   out_data,
    output logic                    out_sat,
    output logic [NCH-1:0]          sat_sticky
);

    logic [NCH-1:0][WIDTH-1:0] acc;

    logic             accept_c;
    logic             ch_ok_c;
    acc_mode_e        mode_c;
    logic [WIDTH-1:0] cur_c;
    logic [WIDTH-1:0] sum_c;
    logic             sat_c;
    logic [WIDTH-1:0] next_c;
    logic             next_sat_c;
    logic [WIDTH:0]   ext_c;

    // No skid buffer: the output register can take a new result only if it is empty or draining.
    assign in_ready = !rst && (!out_valid || out_ready);

    always_comb begin
        ch_ok_c    = {1'b0, in_ch} < (CHW + 1)'(NCH);
        accept_c   = in_valid && in_ready;
        cur_c      = '0;
        mode_c     = ACC_UNSIGNED;
        if (ch_ok_c) begin
            cur_c  = acc[in_ch];
            mode_c = SIGNED_MASK[in_ch] ? ACC_SIGNED : ACC_UNSIGNED;
        end
        next_c     = in_clear ? in_data : sum_c;
        next_sat_c = !in_clear && sat_c;
        ext_c      = (mode_c == ACC_SIGNED) ? {next_c[WIDTH-1], next_c} : {1'b0, next_c};
    end

    acc_sat_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .mode  (mode_c),
        .a     (cur_c),
        .b     (in_data),
        .sum_c (sum_c),
        .sat_c (sat_c)
    );

    // Accumulators and result register; out-of-range channels are consumed without effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            sat_sticky <= '0;
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_data   <= '0;
            out_sat    <= 1'b0;
        end else if (accept_c && ch_ok_c) begin
            acc[in_ch]        <= next_c;
            sat_sticky[in_ch] <= !in_clear && (sat_sticky[in_ch] || sat_c);
            out_valid         <= 1'b1;
            out_ch            <= in_ch;
            out_data          <= ext_c;
            out_sat           <= next_sat_c;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_acc_sat_chan.sv
// Directed and randomized checks of acc_sat_chan (WIDTH=4, ch0 signed, ch1 unsigned)
// against an integer reference model of the channel sums and the result register.
module tb_acc_sat_chan;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [0:0]        in_ch;
    logic [3:0]        in_data;
    logic              in_clear;
    logic              out_valid;
    logic              out_ready;
    logic [0:0]        out_ch;
    logic signed [4:0] out_data;
    logic              out_sat;
    logic [1:0]        sat_sticky;

    int vectors     = 0;
    int miscompares = 0;

    int       m_acc [2];
    bit [1:0] m_sticky;
    bit       e_valid;
    bit       e_ch;
    int       e_val;
    bit       e_sat;

    always #5 clk = ~clk;

    acc_sat_chan #(
        .WIDTH       (4),
        .NCH         (2),
        .SIGNED_MASK (2'b01)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch      (in_ch),
        .in_data    (in_data),
        .in_clear   (in_clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .sat_sticky (sat_sticky)
    );

    function automatic int interp(bit ch, logic [3:0] d);
        if (ch == 1'b0) return (d >= 4'd8) ? int'(d) - 16 : int'(d);
        return int'(d);
    endfunction

    task automatic apply(input bit r, input bit v, input bit ch, input logic [3:0] d,
                         input bit clr, input bit ordy);
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        in_ch     = ch;
        in_data   = d;
        in_clear  = clr;
        out_ready = ordy;
        #1;
    endtask

    // Advance one clock and update the reference model from the inputs present at the edge.
    task automatic step();
        bit take;
        int s;
        int lo;
        int hi;
        take = !rst && in_valid && (!e_valid || out_ready);
        @(posedge clk);
        if (rst) begin
            m_acc[0] = 0; m_acc[1] = 0; m_sticky = 2'b00;
            e_valid = 0; e_ch = 0; e_val = 0; e_sat = 0;
        end else if (take) begin
            if (in_clear) begin
                s = interp(in_ch, in_data);
                e_sat = 0;
                m_sticky[in_ch] = 1'b0;
            end else begin
                s  = m_acc[in_ch] + interp(in_ch, in_data);
                lo = (in_ch == 1'b0) ? -8 : 0;
                hi = (in_ch == 1'b0) ? 7 : 15;
                e_sat = (s > hi) || (s < lo);
                if (s > hi) s = hi;
                if (s < lo) s = lo;
                if (e_sat) m_sticky[in_ch] = 1'b1;
            end
            m_acc[in_ch] = s;
            e_valid = 1; e_ch = in_ch; e_val = s;
        end else if (e_valid && out_ready) begin
            e_valid = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        apply(1, 1, 0, 4'd3, 0, 1);
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_ready: in_ready=%b want 0", in_ready);
        end
        step();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 5'sd0 || out_ch !== 1'b0 || out_sat !== 1'b0
            || sat_sticky !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b data=%0d ch=%b sat=%b sticky=%b want all 0",
                     out_valid, out_data, out_ch, out_sat, sat_sticky);
        end
        apply(0, 0, 0, 4'd0, 0, 1);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_release_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_signed_pos_clamp();
        apply(0, 1, 0, 4'd7, 1, 1); step();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 5'sd7 || out_sat !== 1'b0) begin
            miscompares++;
            $display("FAIL spos_clear: valid=%b data=%0d sat=%b want 1/7/0", out_valid, out_data, out_sat);
        end
        apply(0, 1, 0, 4'd3, 0, 1); step();
        vectors++;
        if (out_data !== 5'sd7 || out_sat !== 1'b1 || sat_sticky !== 2'b01) begin
            miscompares++;
            $display("FAIL spos_clamp: data=%0d sat=%b sticky=%b want 7/1/01", out_data, out_sat, sat_sticky);
        end
    endtask

    task automatic test_signed_neg_clamp();
        apply(0, 1, 0, 4'b1000, 1, 1); step();
        apply(0, 1, 0, 4'b1111, 0, 1); step();
        vectors++;
        if (out_data !== 5'sb11000 || out_sat !== 1'b1) begin
            miscompares++;
            $display("FAIL sneg_clamp: data=%b sat=%b want 11000/1", out_data, out_sat);
        end
        apply(0, 1, 0, 4'd2, 1, 1); step();
        vectors++;
        if (out_data !== 5'sd2 || out_sat !== 1'b0 || sat_sticky[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL sneg_clear: data=%0d sat=%b sticky0=%b want 2/0/0", out_data, out_sat, sat_sticky[0]);
        end
    endtask

    task automatic test_unsigned_clamp();
        apply(0, 1, 1, 4'd15, 1, 1); step();
        apply(0, 1, 1, 4'd1, 0, 1); step();
        vectors++;
        if (out_data !== 5'sb01111 || out_sat !== 1'b1 || out_ch !== 1'b1 || sat_sticky[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL uns_clamp: data=%b sat=%b ch=%b sticky1=%b want 01111/1/1/1",
                     out_data, out_sat, out_ch, sat_sticky[1]);
        end
        apply(0, 1, 1, 4'b1000, 1, 1); step();
        vectors++;
        if (out_data !== 5'sd8) begin
            miscompares++; $display("FAIL uns_extend: data=%0d want 8", out_data);
        end
    endtask

    task automatic test_back_to_back();
        bit ch_seq  [5] = '{0, 1, 0, 1, 0};
        int add_seq [5] = '{1, 2, 1, 2, 1};
        int exp_seq [5] = '{1, 2, 2, 4, 3};
        apply(0, 1, 0, 4'd0, 1, 1); step();
        apply(0, 1, 1, 4'd0, 1, 1); step();
        for (int i = 0; i < 5; i++) begin
            apply(0, 1, ch_seq[i], 4'(add_seq[i]), 0, 1);
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_ch !== ch_seq[i] || out_data !== 5'(exp_seq[i])) begin
                miscompares++;
                $display("FAIL chain_%0d: valid=%b ch=%b data=%0d want 1/%b/%0d",
                         i, out_valid, out_ch, out_data, ch_seq[i], exp_seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        apply(0, 1, 0, 4'd1, 0, 1); step();
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 0, 4'd5, 0, 0);
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++; $display("FAIL bp_ready_%0d: in_ready=%b want 0", i, in_ready);
            end
            step();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 5'sd4 || out_ch !== 1'b0 || out_sat !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold_%0d: valid=%b data=%0d ch=%b sat=%b want 1/4/0/0",
                         i, out_valid, out_data, out_ch, out_sat);
            end
        end
        apply(0, 1, 0, 4'd1, 0, 1);
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL bp_release_ready: in_ready=%b want 1", in_ready);
        end
        step();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 5'sd5) begin
            miscompares++; $display("FAIL bp_release: valid=%b data=%0d want 1/5", out_valid, out_data);
        end
    endtask

    task automatic test_reset_midstream();
        apply(1, 0, 0, 4'd0, 0, 0); step();
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 5'sd0 || out_sat !== 1'b0 || out_ch !== 1'b0
            || sat_sticky !== 2'b00) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b data=%0d sat=%b ch=%b sticky=%b want all 0",
                     out_valid, out_data, out_sat, out_ch, sat_sticky);
        end
        apply(0, 1, 0, 4'd1, 0, 1); step();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 5'sd1) begin
            miscompares++; $display("FAIL mid_after: valid=%b data=%0d want 1/1", out_valid, out_data);
        end
    endtask

    task automatic test_random();
        bit exp_rdy;
        for (int i = 0; i < 600; i++) begin
            apply(($urandom_range(63) == 0), ($urandom_range(3) != 0), 1'($urandom_range(1)),
                  4'($urandom_range(15)), ($urandom_range(7) == 0), ($urandom_range(3) != 0));
            exp_rdy = !rst && (!e_valid || out_ready);
            vectors++;
            if (in_ready !== exp_rdy) begin
                miscompares++; $display("FAIL rnd_ready_%0d: in_ready=%b want %b", i, in_ready, exp_rdy);
            end
            step();
            vectors++;
            if (out_valid !== e_valid || sat_sticky !== m_sticky) begin
                miscompares++;
                $display("FAIL rnd_ctrl_%0d: valid=%b sticky=%b want %b/%b", i, out_valid, sat_sticky, e_valid, m_sticky);
            end
            if (e_valid) begin
                vectors++;
                if (out_ch !== e_ch || out_data !== 5'(e_val) || out_sat !== e_sat) begin
                    miscompares++;
                    $display("FAIL rnd_data_%0d: ch=%b data=%0d sat=%b want %b/%0d/%b",
                             i, out_ch, out_data, out_sat, e_ch, e_val, e_sat);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_ch = 1'b0; in_data = 4'd0; in_clear = 1'b0; out_ready = 1'b1;
        m_acc[0] = 0; m_acc[1] = 0; m_sticky = 2'b00;
        e_valid = 0; e_ch = 0; e_val = 0; e_sat = 0;
        test_reset();
        test_signed_pos_clamp();
        test_signed_neg_clamp();
        test_unsigned_clamp();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/acc_sat_chan.md
# acc_sat_chan

Multi-channel saturating accumulator. It is the parametrised successor of the fixed 4-bit signed/unsigned output pair. Each of NCH channels holds a WIDTH-bit running sum, and each channel is independently signed or unsigned. Samples arrive on a valid/ready stream tagged with a channel index. Each accepted sample updates its channel and emits the new sum, one cycle later, on a registered valid/ready output stream. The block sits between sample producers and downstream statistics/threshold logic.

## Interface
- WIDTH, 4, accumulator and input sample width (≥2)
- NCH, 2, channel count (≥1)
- SIGNED_MASK, {NCH{1'b1}}, bit c = 1: channel c is two's-complement signed; 0: unsigned
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample this cycle
- in_ch  in  $clog2(NCH) (min 1)  target channel
- in_data  in  WIDTH  sample, interpreted per channel mode
- in_clear  in  1  load sample instead of adding
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_ch  out  $clog2(NCH)  channel of result
- out_data  out  WIDTH+1 signed  new sum: sign-extended (signed ch) or zero-extended (unsigned ch)
- out_sat  out  1  this update clamped
- sat_sticky  out  NCH  per-channel sticky saturation flag

## Operation
- Accept when in_valid && in_ready. in_ready = !rst && (!out_valid || out_ready), combinational.
- On accept with in_clear=1: acc[in_ch] ← in_data; sat_sticky[in_ch] ← 0; out_sat ← 0.
- On accept with in_clear=0, compute sum = acc + in_data in WIDTH+1 bits, using the channel's interpretation.
  - Signed channel: clamp to [−2^(W−1), 2^(W−1)−1].
  - Unsigned channel: clamp to [0, 2^W−1].
  - Store the clamped value. out_sat = clamp occurred. sat_sticky[in_ch] |= out_sat.
- Result register is loaded on accept: out_valid←1, out_ch, out_data (extended new acc), out_sat.
- If out_valid && out_ready and there is no accept: out_valid←0. Other out_* hold their last value.
- Out-of-range in_ch (≥NCH): the sample is accepted and dropped. No state change, no output.
- Output is a single stage with no skid buffer. Backpressure propagates combinationally to in_ready.

## Timing
- Reset (synchronous, takes priority over all activity): every acc=0, sat_sticky=0, out_valid=0, out_ch=0, out_data=0, out_sat=0; in_ready=0 while rst is high.
- Reset mid-operation discards any pending result and all sums. First accept is possible in the first cycle after rst deasserts.
- Latency: accept in cycle N → out_valid in cycle N+1 with the updated sum.
- Throughput: 1 sample/cycle while out_ready=1.
- Back-to-back samples to the same channel must chain. The accumulator array is updated in the accept cycle, so cycle N+1 reads the sum from cycle N. No bypass is needed.
- out_* are stable while out_valid && !out_ready.
- Simultaneous out handshake and new accept in the same cycle: the register is replaced and out_valid stays 1.

## Structure
- Package acc_pkg:
  - typedef for the channel mode enum (ACC_UNSIGNED, ACC_SIGNED).
  - function sat_add(mode, a, b, W) returning {sat, value}.
  - Localparams for clamp limits.
- Sub-module acc_sat_add is combinational. It performs the WIDTH+1 extension, add and clamp, and is instantiated once; the channel mux sits in front of it.
- The accumulator array is a register vector indexed by in_ch.

## Test plan
WIDTH=4, NCH=2, SIGNED_MASK=2'b01 (ch0 signed, ch1 unsigned).
1. Signed positive clamp. ch0: clear 7, then add 3 → out_data +7/sat=0, then +7/sat=1. sat_sticky=2'b01.
2. Signed negative clamp. ch0: clear 4'b1000 (−8), then add 4'b1111 (−1) → −8 (5'sb11000), sat=1. A following clear of 2 → +2 and sat_sticky[0]=0.
3. Unsigned clamp and extension. ch1: clear 15, then add 1 → out_data 5'sb01111 (+15), sat=1. Then clear 4'b1000 → +8, not −8.
4. Chaining and interleave. ch0 +1 on three consecutive cycles interleaved with ch1 +2 ×2 → in-order outputs ch0:1, ch1:2, ch0:2, ch1:4, ch0:3, one per cycle.
5. Backpressure. Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, out_* frozen, acc unchanged. Release → next sample is accepted the same cycle.
6. Reset mid-stream. Assert rst with out_valid=1 and ch0=5 → next cycle out_valid=0, all outputs 0. After release, ch0 add 1 → out_data +1.
